// File: rtl/rtc_seg_display.sv
// Real-time clock (HH:MM:SS, 24 h) with an 8-digit multiplexed 7-segment driver.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   run_en            1 = time advances, 0 = time and prescaler frozen
//   time_set          one-cycle load strobe for sec_in/min_in/hour_in
//   blink_sel         00 none, 01 hours, 10 minutes, 11 seconds
//   sec/min/hour      current time, binary
//   tick              one-cycle pulse per count increment
//   day_wrap          one-cycle pulse on 23:59:59 -> 00:00:00
//   set_err           one-cycle pulse when a load is rejected
//   seg_en            one-hot digit enable (active-high)
//   seg_out0/seg_out1 segment buses {a..g,dp} for digits 7..4 / 3..0
module rtc_seg_display #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned SCAN_HZ = 400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       time_set,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic [1:0] blink_sel,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       tick,
  output logic       day_wrap,
  output logic       set_err,
  output logic [7:0] seg_en,
  output logic [7:0] seg_out0,
  output logic [7:0] seg_out1
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW       = $clog2(TICK_DIV);
  localparam int unsigned SW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [2:0]    scan_idx;

  logic       load_ok;
  logic       presc_last;
  logic       blank_phase;
  logic [3:0] digit_val;
  logic       is_dash;
  logic       blink_hit;
  logic [7:0] glyph;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 8'hFC;
      4'd1:    digit_glyph = 8'h60;
      4'd2:    digit_glyph = 8'hDA;
      4'd3:    digit_glyph = 8'hF2;
      4'd4:    digit_glyph = 8'h66;
      4'd5:    digit_glyph = 8'hB6;
      4'd6:    digit_glyph = 8'hBE;
      4'd7:    digit_glyph = 8'hE0;
      4'd8:    digit_glyph = 8'hFE;
      4'd9:    digit_glyph = 8'hF6;
      default: digit_glyph = 8'h00;
    endcase
  endfunction

  assign load_ok    = time_set && (sec_in < 6'd60) && (min_in < 6'd60) && (hour_in < 5'd24);
  assign presc_last = (presc == PW'(TICK_DIV - 1));

  // Prescaler, time counters and status pulses; a valid load overrides any wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      tick     <= 1'b0;
      day_wrap <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      tick     <= 1'b0;
      day_wrap <= 1'b0;
      set_err  <= 1'b0;
      if (load_ok) begin
        sec   <= sec_in;
        min   <= min_in;
        hour  <= hour_in;
        presc <= '0;
      end else begin
        if (time_set) set_err <= 1'b1;
        if (run_en) begin
          if (presc_last) begin
            presc <= '0;
            tick  <= 1'b1;
            if (sec == 6'd59) begin
              sec <= '0;
              if (min == 6'd59) begin
                min <= '0;
                if (hour == 5'd23) begin
                  hour     <= '0;
                  day_wrap <= 1'b1;
                end else begin
                  hour <= hour + 5'd1;
                end
              end else begin
                min <= min + 6'd1;
              end
            end else begin
              sec <= sec + 6'd1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
      end
    end
  end

  // Free-running digit scan, independent of run_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Blink phase follows the prescaler, so it freezes together with time.
  assign blank_phase = (presc >= PW'(TICK_DIV / 2));

  // Select the digit value for the current scan position.
  always_comb begin
    digit_val = '0;
    is_dash   = 1'b0;
    blink_hit = 1'b0;
    case (scan_idx)
      3'd0: begin digit_val = 4'(sec % 6'd10);  blink_hit = (blink_sel == 2'b11); end
      3'd1: begin digit_val = 4'(sec / 6'd10);  blink_hit = (blink_sel == 2'b11); end
      3'd3: begin digit_val = 4'(min % 6'd10);  blink_hit = (blink_sel == 2'b10); end
      3'd4: begin digit_val = 4'(min / 6'd10);  blink_hit = (blink_sel == 2'b10); end
      3'd6: begin digit_val = 4'(hour % 5'd10); blink_hit = (blink_sel == 2'b01); end
      3'd7: begin digit_val = 4'(hour / 5'd10); blink_hit = (blink_sel == 2'b01); end
      default: is_dash = 1'b1;
    endcase
    if (is_dash)                       glyph = 8'h02;
    else if (blink_hit && blank_phase) glyph = 8'h00;
    else                               glyph = digit_glyph(digit_val);
  end

  // Registered digit enable and bank routing; the idle bank is driven dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_en   <= '0;
      seg_out0 <= '0;
      seg_out1 <= '0;
    end else begin
      seg_en   <= 8'(1) << scan_idx;
      seg_out0 <= scan_idx[2] ? glyph : 8'h00;
      seg_out1 <= scan_idx[2] ? 8'h00 : glyph;
    end
  end

endmodule
